// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: scans a 32-bit display word as 8 hex digits onto a
// common-anode 7-segment bank and generates the one-second flag1s pulse.
// Anodes, segments and decimal point are active-low and registered, so they
// lag the scan position by one cycle.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV  = 100000,    // clock cycles per digit slot (>= 2)
   parameter int BLANK_CYC = 100,       // anti-ghost cycles at slot start (< SCAN_DIV)
   parameter int SEC_DIV   = 100000000  // clock cycles per flag1s period (>= 2)
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] data_i,
   input  logic        lzb_en_i,
   input  logic [7:0]  dp_mask_i,
   output logic        flag1s_o,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o
);

   localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int SEC_W  = (SEC_DIV > 2) ? $clog2(SEC_DIV) : 1;

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0] BLANK_END = SCAN_W'(BLANK_CYC);
   localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);

   // Hex digit to active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   logic [SEC_W-1:0]  r_sec_cnt;
   logic              r_flag1s;
   logic [SCAN_W-1:0] r_scan_cnt;
   logic [2:0]        r_idx;
   logic [31:0]       r_shadow;
   logic              r_lzb_q;
   logic [7:0]        r_dp_q;
   logic              r_first;
   logic [7:0]        r_an;
   logic [6:0]        r_seg;
   logic              r_dp;

   logic              w_scan_wrap;
   logic              w_load;
   logic [3:0]        w_nibble;
   logic [7:0]        w_lz_blank;
   logic              w_zero_run;
   logic [7:0]        w_an_nxt;
   logic [6:0]        w_seg_nxt;
   logic              w_dp_nxt;

   assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
   // Frame 0 is latched on the first edge after reset so live data shows at once.
   assign w_load      = r_first | (w_scan_wrap & (r_idx == 3'd7));
   assign w_nibble    = r_shadow[{r_idx, 2'b00} +: 4];

   // Free-running second counter; flag1s is high the cycle after the terminal count.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_sec_cnt <= '0;
         r_flag1s  <= 1'b0;
      end else begin
         r_flag1s  <= (r_sec_cnt == SEC_LAST);
         r_sec_cnt <= (r_sec_cnt == SEC_LAST) ? '0 : r_sec_cnt + SEC_W'(1);
      end
   end

   // Slot timer and digit index; the index advances when the slot timer wraps.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_scan_cnt <= '0;
         r_idx      <= 3'd0;
      end else begin
         r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
         if (w_scan_wrap) r_idx <= r_idx + 3'd1;
      end
   end

   // Frame latch: display settings are frozen for a whole 8-digit frame.
   // NOTE: the shadow is a handful of flops, not a RAM, so it is reset to a known blank-safe value.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_first  <= 1'b1;
         r_shadow <= '0;
         r_lzb_q  <= 1'b0;
         r_dp_q   <= '0;
      end else begin
         r_first <= 1'b0;
         if (w_load) begin
            r_shadow <= data_i;
            r_lzb_q  <= lzb_en_i;
            r_dp_q   <= dp_mask_i;
         end
      end
   end

   // Leading-zero mask: digit k blanks when nibbles k..7 are all zero; digit 0 never blanks.
   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_lz_blank = '0;
      w_zero_run = 1'b1;
      for (int k = 7; k >= 1; k--) begin
         w_zero_run    = w_zero_run & (r_shadow[4*k +: 4] == 4'h0);
         w_lz_blank[k] = r_lzb_q & w_zero_run;
      end
   end

   // Next anode/segment/dp values: dark during ghost blanking or an LZ-blanked digit.
   always_comb begin
      w_an_nxt  = 8'hFF;
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
      if ((r_scan_cnt >= BLANK_END) && !w_lz_blank[r_idx]) begin
         w_an_nxt  = ~(8'b1 << r_idx);
         w_seg_nxt = seg_decode(w_nibble);
         w_dp_nxt  = ~r_dp_q[r_idx];
      end
   end

   // Output registers, one cycle behind the scan position.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_an  <= 8'hFF;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   assign flag1s_o = r_flag1s;
   assign an_o     = r_an;
   assign seg_o    = r_seg;
   assign dp_o     = r_dp;

endmodule
